// File: rtl/regfile_sb.sv
// regfile_sb: multi-port integer register file with an in-flight write
// scoreboard that decode uses for RAW-hazard stalls.
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   we/waddr/wdata        NWP writeback ports (always accepted, no handshake)
//   re/raddr -> rdata     NRP combinational read ports
//   rbusy                 per read port: addressed register has a pending write
//   issue_valid/issue_rd  decode announces an instruction that will write issue_rd
//   issue_ready           issue accepted this cycle (combinational)
//   sb_err                sticky: a writeback hit a register with zero in-flight count
//
// Handshake: an issue is accepted on a rising edge where issue_valid and
// issue_ready are both 1. issue_ready never depends on issue_valid, so decode
// may look at it before deciding to issue. Issues to x0 are always ready and
// never counted.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRP  = 2,
  parameter int NWP  = 2,
  parameter int FWD  = 1,
  parameter int CW   = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWP-1:0]      we,
  input  logic [NWP*AW-1:0]   waddr,
  input  logic [NWP*XLEN-1:0] wdata,
  input  logic [NRP-1:0]      re,
  input  logic [NRP*AW-1:0]   raddr,
  output logic [NRP*XLEN-1:0] rdata,
  output logic [NRP-1:0]      rbusy,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  output logic                issue_ready,
  output logic                sb_err
);

  localparam int WBW = $clog2(NWP + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [CW-1:0]   cnt_q  [NREG];
  logic [CW-1:0]   cnt_d  [NREG];
  logic            sb_err_q;
  logic            sb_err_d;
  logic [WBW-1:0]  wb_num [NREG];
  logic            issue_acc;
  int              net;

  // Number of writeback ports targeting each register this cycle (x0 excluded).
  always_comb begin
    for (int r = 0; r < NREG; r++) wb_num[r] = '0;
    for (int k = 0; k < NWP; k++) begin
      if (we[k] && waddr[k*AW +: AW] != '0)
        wb_num[waddr[k*AW +: AW]] = wb_num[waddr[k*AW +: AW]] + WBW'(1);
    end
  end

  // A full counter still accepts an issue when a writeback to the same
  // register frees a slot in the same cycle.
  always_comb begin
    issue_ready = 1'b1;
    if (rst && issue_rd != '0 && cnt_q[issue_rd] == CNT_MAX && wb_num[issue_rd] == '0)
      issue_ready = 1'b0;
  end

  assign issue_acc = rst & issue_valid & issue_ready & (issue_rd != '0);

  // Storage and scoreboard next state.
  always_comb begin
    regs_d   = regs_q;
    sb_err_d = sb_err_q;
    net      = 0;
    // Ascending port order so the highest-index port wins on a collision.
    for (int k = 0; k < NWP; k++) begin
      if (we[k]) regs_d[waddr[k*AW +: AW]] = wdata[k*XLEN +: XLEN];
    end
    regs_d[0] = '0;
    cnt_d[0]  = '0;
    for (int r = 1; r < NREG; r++) begin
      // Issue and writebacks are netted so a simultaneous +1/-1 is a no-op.
      net = int'(cnt_q[r]) - int'(wb_num[r]);
      if (issue_acc && issue_rd == AW'(r)) net = net + 1;
      if (net < 0) begin
        cnt_d[r] = '0;
        sb_err_d = 1'b1;
      end else begin
        cnt_d[r] = CW'(net);
      end
    end
  end

  // Read ports and busy flags; everything reads as idle while in reset.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int p = 0; p < NRP; p++) begin
      if (rst && re[p] && raddr[p*AW +: AW] != '0) begin
        rdata[p*XLEN +: XLEN] = regs_q[raddr[p*AW +: AW]];
        if (FWD != 0) begin
          for (int k = 0; k < NWP; k++) begin
            if (we[k] && waddr[k*AW +: AW] == raddr[p*AW +: AW])
              rdata[p*XLEN +: XLEN] = wdata[k*XLEN +: XLEN];
          end
          // With bypass, the final writeback already delivers the data,
          // so the register stops being busy in that same cycle.
          rbusy[p] = int'(cnt_q[raddr[p*AW +: AW]]) > int'(wb_num[raddr[p*AW +: AW]]);
        end else begin
          rbusy[p] = cnt_q[raddr[p*AW +: AW]] != '0;
        end
      end
    end
  end

  assign sb_err = sb_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      cnt_q    <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed testbench for regfile_sb. Two instances share write and issue
// inputs: u_fwd (FWD=1, three read ports) and u_nof (FWD=0, two read ports).
// Inputs are driven on the falling edge and outputs checked 1 ns later.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [2:0]  re;
  logic [14:0] raddr;
  logic [95:0] rdata;
  logic [2:0]  rbusy;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        sb_err;
  logic [1:0]  re_n;
  logic [9:0]  raddr_n;
  logic [63:0] rdata_n;
  logic [1:0]  rbusy_n;
  logic        issue_ready_n;
  logic        sb_err_n;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(32), .NREG(32), .NRP(3), .NWP(2), .FWD(1), .CW(2)) u_fwd (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .sb_err(sb_err)
  );

  regfile_sb #(.XLEN(32), .NREG(32), .NRP(2), .NWP(2), .FWD(0), .CW(2)) u_nof (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re_n), .raddr(raddr_n), .rdata(rdata_n), .rbusy(rbusy_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready_n),
    .sb_err(sb_err_n)
  );

  // ---------------- driver tasks ----------------
  task automatic idle();
    we = '0; waddr = '0; wdata = '0;
    re = '0; raddr = '0; re_n = '0; raddr_n = '0;
    issue_valid = 1'b0; issue_rd = '0;
  endtask

  task automatic set_wr(input int k, input logic [4:0] a, input logic [31:0] d);
    we[k] = 1'b1; waddr[k*5 +: 5] = a; wdata[k*32 +: 32] = d;
  endtask

  task automatic set_rd(input int p, input logic [4:0] a);
    re[p] = 1'b1; raddr[p*5 +: 5] = a;
  endtask

  task automatic set_rd_n(input int p, input logic [4:0] a);
    re_n[p] = 1'b1; raddr_n[p*5 +: 5] = a;
  endtask

  function automatic logic [31:0] rd(input int p);
    return rdata[p*32 +: 32];
  endfunction

  function automatic logic [31:0] rd_n(input int p);
    return rdata_n[p*32 +: 32];
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle();
    #1 rst = 1'b0;
    // Activity during reset must be invisible and ignored.
    set_wr(0, 5'd4, 32'h1234_5678);
    set_rd(0, 5'd4); set_rd_n(0, 5'd4);
    issue_valid = 1'b1; issue_rd = 5'd4;
    #1;
    checks++; if (rd(0) !== 32'h0) begin errors++; $display("FAIL reset_rdata_fwd got=%h exp=%h", rd(0), 32'h0); end
    checks++; if (rd_n(0) !== 32'h0) begin errors++; $display("FAIL reset_rdata_nof got=%h exp=%h", rd_n(0), 32'h0); end
    checks++; if (rbusy !== 3'b000) begin errors++; $display("FAIL reset_rbusy got=%b exp=%b", rbusy, 3'b000); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got=%b exp=1", issue_ready); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb_err got=%b exp=0", sb_err); end
    @(negedge clk);
    idle();
    rst = 1'b1;
    set_rd(0, 5'd4); set_rd_n(0, 5'd4);
    #1;
    checks++; if (rd(0) !== 32'h0) begin errors++; $display("FAIL reset_write_ignored got=%h exp=%h", rd(0), 32'h0); end
    checks++; if (rbusy[0] !== 1'b0) begin errors++; $display("FAIL reset_issue_ignored got=%b exp=0", rbusy[0]); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb_err_after got=%b exp=0", sb_err); end
    idle();
    step();
  endtask

  task automatic test_x0();
    set_wr(0, 5'd0, 32'hFFFF_FFFF);
    set_rd(0, 5'd0);
    #1;
    checks++; if (rd(0) !== 32'h0) begin errors++; $display("FAIL x0_same_cycle got=%h exp=%h", rd(0), 32'h0); end
    step();
    idle();
    set_rd(0, 5'd0); set_rd_n(0, 5'd0);
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1;
    checks++; if (rd(0) !== 32'h0) begin errors++; $display("FAIL x0_read_fwd got=%h exp=%h", rd(0), 32'h0); end
    checks++; if (rd_n(0) !== 32'h0) begin errors++; $display("FAIL x0_read_nof got=%h exp=%h", rd_n(0), 32'h0); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL x0_issue_ready got=%b exp=1", issue_ready); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL x0_not_tracked got=%b exp=0", sb_err); end
    step();
    idle();
    set_rd(0, 5'd0);
    #1;
    checks++; if (rbusy[0] !== 1'b0) begin errors++; $display("FAIL x0_rbusy got=%b exp=0", rbusy[0]); end
    idle();
    step();
  endtask

  task automatic test_bypass_priority();
    set_wr(0, 5'd3, 32'h11);
    set_wr(1, 5'd3, 32'h22);
    set_rd(1, 5'd3); set_rd_n(0, 5'd3);
    #1;
    checks++; if (rd(1) !== 32'h22) begin errors++; $display("FAIL bypass_high_port got=%h exp=%h", rd(1), 32'h22); end
    checks++; if (rd_n(0) !== 32'h0) begin errors++; $display("FAIL nofwd_old_value got=%h exp=%h", rd_n(0), 32'h0); end
    step();
    idle();
    set_rd(0, 5'd3); set_rd_n(1, 5'd3);
    #1;
    checks++; if (rd(0) !== 32'h22) begin errors++; $display("FAIL storage_priority_fwd got=%h exp=%h", rd(0), 32'h22); end
    checks++; if (rd_n(1) !== 32'h22) begin errors++; $display("FAIL storage_priority_nof got=%h exp=%h", rd_n(1), 32'h22); end
    // Both writebacks targeted a register with no issued writes.
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL untracked_wb_err got=%b exp=1", sb_err); end
    checks++; if (sb_err_n !== 1'b1) begin errors++; $display("FAIL untracked_wb_err_nof got=%b exp=1", sb_err_n); end
    do_reset();
  endtask

  task automatic test_multi_read();
    set_wr(0, 5'd1, 32'hA);
    set_wr(1, 5'd2, 32'hB);
    step();
    idle();
    set_rd(0, 5'd1); set_rd(1, 5'd2); set_rd(2, 5'd1);
    #1;
    checks++; if (rd(0) !== 32'hA) begin errors++; $display("FAIL mread_p0 got=%h exp=%h", rd(0), 32'hA); end
    checks++; if (rd(1) !== 32'hB) begin errors++; $display("FAIL mread_p1 got=%h exp=%h", rd(1), 32'hB); end
    checks++; if (rd(2) !== 32'hA) begin errors++; $display("FAIL mread_p2 got=%h exp=%h", rd(2), 32'hA); end
    re[1] = 1'b0;
    #1;
    checks++; if (rd(1) !== 32'h0) begin errors++; $display("FAIL mread_re0 got=%h exp=%h", rd(1), 32'h0); end
    checks++; if (rd(2) !== 32'hA) begin errors++; $display("FAIL mread_p2_kept got=%h exp=%h", rd(2), 32'hA); end
    idle();
    step();
    do_reset();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; issue_rd = 5'd7;
      #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sat_issue%0d_ready got=%b exp=1", i, issue_ready); end
      step();
    end
    issue_valid = 1'b1; issue_rd = 5'd7;
    set_rd(0, 5'd7);
    #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL sat_full_stall got=%b exp=0", issue_ready); end
    checks++; if (rbusy[0] !== 1'b1) begin errors++; $display("FAIL sat_rbusy got=%b exp=1", rbusy[0]); end
    set_wr(0, 5'd7, 32'h77);
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sat_wb_frees got=%b exp=1", issue_ready); end
    checks++; if (rbusy[0] !== 1'b1) begin errors++; $display("FAIL sat_rbusy_wb got=%b exp=1", rbusy[0]); end
    step();
    idle();
    // Count must still be 3: issue alone stalls again.
    issue_valid = 1'b1; issue_rd = 5'd7;
    set_rd_n(0, 5'd7);
    #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL sat_count_kept got=%b exp=0", issue_ready); end
    checks++; if (rbusy_n[0] !== 1'b1) begin errors++; $display("FAIL sat_rbusy_nof got=%b exp=1", rbusy_n[0]); end
    idle();
    // Drain: two ports to x7 take 2, leaving 1.
    set_wr(0, 5'd7, 32'h70); set_wr(1, 5'd7, 32'h71);
    set_rd(0, 5'd7);
    #1;
    checks++; if (rbusy[0] !== 1'b1) begin errors++; $display("FAIL drain_dual_busy got=%b exp=1", rbusy[0]); end
    checks++; if (rd(0) !== 32'h71) begin errors++; $display("FAIL drain_dual_data got=%h exp=%h", rd(0), 32'h71); end
    step();
    idle();
    set_wr(1, 5'd7, 32'h72);
    set_rd(0, 5'd7);
    #1;
    checks++; if (rbusy[0] !== 1'b0) begin errors++; $display("FAIL drain_last_busy got=%b exp=0", rbusy[0]); end
    step();
    idle();
    #1;
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL drain_no_err got=%b exp=0", sb_err); end
    do_reset();
  endtask

  task automatic test_busy_clear();
    issue_valid = 1'b1; issue_rd = 5'd9;
    set_rd(0, 5'd9); set_rd_n(0, 5'd9);
    #1;
    checks++; if (rbusy[0] !== 1'b0) begin errors++; $display("FAIL busy_same_cycle_issue got=%b exp=0", rbusy[0]); end
    checks++; if (rbusy_n[0] !== 1'b0) begin errors++; $display("FAIL busy_same_cycle_issue_nof got=%b exp=0", rbusy_n[0]); end
    step();
    idle();
    set_rd(0, 5'd9); set_rd_n(0, 5'd9);
    #1;
    checks++; if (rbusy[0] !== 1'b1) begin errors++; $display("FAIL busy_next_cycle got=%b exp=1", rbusy[0]); end
    checks++; if (rbusy_n[0] !== 1'b1) begin errors++; $display("FAIL busy_next_cycle_nof got=%b exp=1", rbusy_n[0]); end
    set_wr(1, 5'd9, 32'h5);
    #1;
    checks++; if (rbusy[0] !== 1'b0) begin errors++; $display("FAIL busy_clear_fwd got=%b exp=0", rbusy[0]); end
    checks++; if (rd(0) !== 32'h5) begin errors++; $display("FAIL busy_clear_data got=%h exp=%h", rd(0), 32'h5); end
    checks++; if (rbusy_n[0] !== 1'b1) begin errors++; $display("FAIL busy_hold_nof got=%b exp=1", rbusy_n[0]); end
    checks++; if (rd_n(0) !== 32'h0) begin errors++; $display("FAIL busy_old_data_nof got=%h exp=%h", rd_n(0), 32'h0); end
    step();
    idle();
    set_rd(0, 5'd9); set_rd_n(0, 5'd9);
    #1;
    checks++; if (rbusy_n[0] !== 1'b0) begin errors++; $display("FAIL busy_clear_nof got=%b exp=0", rbusy_n[0]); end
    checks++; if (rd_n(0) !== 32'h5) begin errors++; $display("FAIL busy_data_nof got=%h exp=%h", rd_n(0), 32'h5); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL busy_no_err got=%b exp=0", sb_err); end
    idle();
    set_wr(0, 5'd9, 32'h6);
    step();
    idle();
    #1;
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL extra_wb_err got=%b exp=1", sb_err); end
    step();
    #1;
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", sb_err); end
    idle();
    step();
  endtask

  task automatic test_reset_midop();
    set_wr(0, 5'd5, 32'hDEAD_BEEF);
    step();
    idle();
    set_rd(0, 5'd5); set_rd_n(0, 5'd5);
    #1;
    checks++; if (rd(0) !== 32'hDEAD_BEEF) begin errors++; $display("FAIL midop_written got=%h exp=%h", rd(0), 32'hDEAD_BEEF); end
    #2 rst = 1'b0;
    #1;
    checks++; if (rd(0) !== 32'h0) begin errors++; $display("FAIL midop_async_fwd got=%h exp=%h", rd(0), 32'h0); end
    checks++; if (rd_n(0) !== 32'h0) begin errors++; $display("FAIL midop_async_nof got=%h exp=%h", rd_n(0), 32'h0); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL midop_async_err got=%b exp=0", sb_err); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (rd(0) !== 32'h0) begin errors++; $display("FAIL midop_after_fwd got=%h exp=%h", rd(0), 32'h0); end
    checks++; if (rd_n(0) !== 32'h0) begin errors++; $display("FAIL midop_after_nof got=%h exp=%h", rd_n(0), 32'h0); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL midop_after_err got=%b exp=0", sb_err); end
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_x0();
    test_bypass_priority();
    test_multi_read();
    test_saturation();
    test_busy_clear();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
